// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences the shared memory/ALU/IR/PC datapath
// per instruction, stalling on memory handshakes with an optional wait timeout.
module multicycle_control #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] OpCode,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       PCEn,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [3:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       illegal_op,
   output logic       mem_timeout,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9
   } state_e;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(MEM_TIMEOUT);
   localparam bit               TMO_EN  = (MEM_TIMEOUT != 0);

   state_e           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wait_st;
   logic             tmo_hit;

   // State, latched opcode and memory wait counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and datapath controls, all forced low while in reset
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      cnt_d       = '0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 4'b0000;
      PCSource    = 2'b00;
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;

      wait_st = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
      tmo_hit = TMO_EN && wait_st && !mem_ready && (cnt_q == TMO_VAL);

      if (!rst) begin
         mem_timeout = tmo_hit;
         // Counter only survives a plain stall; any exit, completion or abort clears it
         if (wait_st && !mem_ready && !tmo_hit)
            cnt_d = (cnt_q == TMO_VAL) ? cnt_q : cnt_q + CNT_W'(1);

         case (state_q)
            FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               if (mem_ready) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
                  state_d = DECODE;
               end
            end
            DECODE: begin
               ALUSrcB = 2'b11;
               op_d    = OpCode;
               case (OpCode)
                  OP_LW, OP_SW: state_d = MEMADR;
                  OP_R:         state_d = EXEC;
                  OP_BEQ:       state_d = BRANCH;
                  OP_J:         state_d = JUMP;
                  default: begin
                     illegal_op = 1'b1;
                     state_d    = FETCH;
                  end
               endcase
            end
            MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
               if (mem_ready)    state_d = MEMWB;
               else if (tmo_hit) state_d = FETCH;
            end
            MEMWB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
               state_d  = FETCH;
            end
            MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
               if (mem_ready || tmo_hit) state_d = FETCH;
            end
            EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = 4'b0010;
               state_d = RWB;
            end
            RWB: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
               state_d  = FETCH;
            end
            BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 4'b0001;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
               state_d     = FETCH;
            end
            JUMP: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
               state_d  = FETCH;
            end
            default: state_d = FETCH;
         endcase
      end
   end

   assign PCEn  = PCWrite | (PCWriteCond & Zero);
   assign state = rst ? FETCH : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: an instruction-level model
// expands each instruction into its expected per-cycle control trace.
module tb_multicycle_control;

   localparam int unsigned TMO = 4;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] OpCode = '0;
   logic       Zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op, mem_timeout;
   logic [1:0] ALUSrcB, PCSource;
   logic [3:0] ALUOp, state;

   multicycle_control #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .OpCode(OpCode), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, pcwc, pcen, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
      logic [1:0] srcb;
      logic [3:0] aluop;
      logic [1:0] pcsrc;
      logic       ill, tmo;
   } ctl_t;

   typedef struct packed {
      logic       r;
      logic [5:0] op;
      logic       z;
      logic       rdy;
      ctl_t       e;
   } cyc_t;

   cyc_t plan[$];
   ctl_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc_no = 0;
   bit   drv_done = 1'b0;

   // Control word each phase presents, straight from the phase descriptions
   function automatic ctl_t phase_ctl(input logic [3:0] s);
      ctl_t c = '0;
      c.st = s;
      case (s)
         4'd0: begin c.mrd = 1; c.srcb = 2'b01; end
         4'd1: c.srcb = 2'b11;
         4'd2: begin c.srca = 1; c.srcb = 2'b10; end
         4'd3: begin c.mrd = 1; c.iord = 1; end
         4'd4: begin c.rw = 1; c.m2r = 1; end
         4'd5: begin c.mwr = 1; c.iord = 1; end
         4'd6: begin c.srca = 1; c.aluop = 4'b0010; end
         4'd7: begin c.rw = 1; c.rdst = 1; end
         4'd8: begin c.srca = 1; c.aluop = 4'b0001; c.pcwc = 1; c.pcsrc = 2'b01; end
         4'd9: begin c.pcw = 1; c.pcen = 1; c.pcsrc = 2'b10; end
         default: ;
      endcase
      return c;
   endfunction

   task automatic add(input ctl_t e, input logic [5:0] op, input logic z, input logic rdy,
                      input logic r = 1'b0);
      cyc_t c;
      c.r = r; c.op = op; c.z = z; c.rdy = rdy; c.e = e;
      plan.push_back(c);
   endtask

   task automatic plain(input logic [3:0] s);
      add(phase_ctl(s), 6'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic rst_cyc(input int n);
      for (int i = 0; i < n; i++) add('0, 6'($urandom), 1'($urandom), 1'($urandom), 1'b1);
   endtask

   // Memory phase that sees w not-ready cycles; abort once TMO stalls have elapsed
   task automatic mem_phase(input logic [3:0] s, input int w, output bit ok);
      bit fin = 0;
      ok = 0;
      for (int k = 0; k <= w && !fin; k++) begin
         ctl_t e = phase_ctl(s);
         if (k == w) begin
            if (s == 4'd0) begin e.irw = 1; e.pcw = 1; e.pcen = 1; end
            add(e, 6'($urandom), 1'($urandom), 1'b1);
            ok = 1; fin = 1;
         end else if (k == int'(TMO)) begin
            e.tmo = 1;
            add(e, 6'($urandom), 1'($urandom), 1'b0);
            fin = 1;
         end else begin
            add(e, 6'($urandom), 1'($urandom), 1'b0);
         end
      end
   endtask

   task automatic do_instr(input logic [5:0] op, input logic z, input int wf, input int wm);
      bit   ok;
      ctl_t e;
      mem_phase(4'd0, wf, ok);
      while (!ok) mem_phase(4'd0, int'($urandom_range(0, TMO)), ok);
      e = phase_ctl(4'd1);
      if (!(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J})) e.ill = 1;
      add(e, op, 1'($urandom), 1'($urandom));
      case (op)
         OP_LW: begin plain(4'd2); mem_phase(4'd3, wm, ok); if (ok) plain(4'd4); end
         OP_SW: begin plain(4'd2); mem_phase(4'd5, wm, ok); end
         OP_R:  begin plain(4'd6); plain(4'd7); end
         OP_BEQ: begin
            e = phase_ctl(4'd8);
            e.pcen = z;
            add(e, 6'($urandom), z, 1'($urandom));
         end
         OP_J:  plain(4'd9);
         default: ;
      endcase
   endtask

   task automatic build_plan();
      bit         ok;
      logic [5:0] ops[5] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};
      logic [5:0] op;
      rst_cyc(2);
      do_instr(OP_R, 1'b0, 0, 0);
      do_instr(OP_LW, 1'b0, 0, 3);
      do_instr(OP_BEQ, 1'b1, 0, 0);
      do_instr(OP_BEQ, 1'b0, 0, 0);
      do_instr(OP_J, 1'b0, 0, 0);
      do_instr(6'b111111, 1'b0, 0, 0);
      do_instr(OP_SW, 1'b0, 0, 10);
      do_instr(OP_SW, 1'b0, 0, int'(TMO));
      do_instr(OP_LW, 1'b0, 0, 0);
      // lw interrupted by reset while stalled in MEMRD
      mem_phase(4'd0, 0, ok);
      add(phase_ctl(4'd1), OP_LW, 1'b0, 1'b1);
      plain(4'd2);
      add(phase_ctl(4'd3), 6'($urandom), 1'b0, 1'b0);
      add(phase_ctl(4'd3), 6'($urandom), 1'b0, 1'b0);
      rst_cyc(2);
      for (int i = 0; i < 60; i++) begin
         op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 4)];
         do_instr(op, 1'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
      end
   endtask

   // Driver: applies one planned cycle per clock and hands its expectation to the scoreboard
   initial begin
      cyc_t c;
      build_plan();
      while (plan.size() > 0) begin
         @(posedge clk);
         #1;
         c = plan.pop_front();
         rst = c.r; OpCode = c.op; Zero = c.z; mem_ready = c.rdy;
         sb.push_back(c.e);
      end
      drv_done = 1'b1;
   end

   // Monitor: compares the whole control vector mid-cycle
   always @(negedge clk) begin
      ctl_t act, exp_c;
      if (sb.size() > 0) begin
         exp_c = sb.pop_front();
         act = '{st: state, pcw: PCWrite, pcwc: PCWriteCond, pcen: PCEn, iord: IorD,
                 mrd: MemRead, mwr: MemWrite, irw: IRWrite, m2r: MemtoReg, rdst: RegDst,
                 rw: RegWrite, srca: ALUSrcA, srcb: ALUSrcB, aluop: ALUOp, pcsrc: PCSource,
                 ill: illegal_op, tmo: mem_timeout};
         checks++;
         if (act !== exp_c) begin
            errors++;
            $display("FAIL ctl cycle %0d: got %07h expected %07h (state got %0d expected %0d)",
                     cyc_no, act, exp_c, act.st, exp_c.st);
         end
         cyc_no++;
      end
   end

   initial begin
      int i;
      for (i = 0; i < 20000 && !(drv_done && sb.size() == 0); i++) @(posedge clk);
      if (!(drv_done && sb.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL run_timeout: got %0d pending expected 0 pending", sb.size() + plan.size());
      end
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
